dmem_arbiter: RTL and testbench

//  Shares the single-port byte-addressed 32-bit data memory between two word requesters:

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_arbiter                                                    |
// | Purpose  : Round-robin req/ack arbiter sharing one single-port 32-bit      |
// |            byte-addressed data memory between port 0 (CPU) and port 1     |
// |            (DMA/loader). Optionally rejects misaligned word accesses.      |
// | Ports    : clk, rst            clock / synchronous active-high reset       |
// |            req/we/addr/wdata N  requester N command (held until ackN)      |
// |            ack/err/rdata N      one-cycle completion, misalign flag, word  |
// |            mem_addr/mem_wdata   memory address / write data (held regs)    |
// |            mem_read/mem_write   memory strobes, high only in ACCESS        |
// |            mem_rdata            combinational read data from memory        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int CHECK_ALIGN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;   // port granted most recently; loser of the next tie
  logic   grant;        // port owning the current transaction

  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;

  // With both ports requesting the port not served last wins; otherwise
  // whichever port is requesting is selected (port 0 when neither is).
  always_comb begin
    sel       = (req0 && req1) ? ~last_grant : req1;
    sel_we    = sel ? we1    : we0;
    sel_addr  = sel ? addr1  : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
  end

  generate
    if (CHECK_ALIGN != 0) begin : g_align_check
      assign misaligned = |sel_addr[1:0];
    end else begin : g_align_pass
      assign misaligned = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant      <= sel;
            last_grant <= sel;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            if (misaligned) begin
              // Rejected without touching memory: complete straight away.
              ack0  <= ~sel;
              ack1  <= sel;
              err0  <= ~sel;
              err1  <= sel;
              state <= DONE;
            end else begin
              mem_read  <= ~sel_we;
              mem_write <= sel_we;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // mem_rdata is only valid while mem_read is high, i.e. here.
          if (mem_read) begin
            if (grant) rdata1 <= mem_rdata;
            else       rdata0 <= mem_rdata;
          end
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          ack0      <= ~grant;
          ack1      <= grant;
          err0      <= 1'b0;
          err1      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err0  <= 1'b0;
          err1  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          ack0      <= 1'b0;
          ack1      <= 1'b0;
          err0      <= 1'b0;
          err1      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_arbiter                                                 |
// | Purpose  : Scoreboard bench for dmem_arbiter with a byte memory model;     |
// |            a second instance with alignment checking disabled.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (alignment checking on)
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, err0, ack1, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write;
  logic [7:0]    mem [0:(1<<AW)-1];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CHECK_ALIGN(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Garbage when not reading so any out-of-ACCESS sampling shows up.
  assign mem_rdata = mem_read ? {mem[mem_addr + 14'd3], mem[mem_addr + 14'd2],
                                 mem[mem_addr + 14'd1], mem[mem_addr]} : 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr]         <= mem_wdata[7:0];
      mem[mem_addr + 14'd1] <= mem_wdata[15:8];
      mem[mem_addr + 14'd2] <= mem_wdata[23:16];
      mem[mem_addr + 14'd3] <= mem_wdata[31:24];
    end
  end

  // Second instance (alignment checking off), only port 1 exercised
  logic          n_req0, n_we0, n_req1, n_we1;
  logic [AW-1:0] n_addr0, n_addr1;
  logic [DW-1:0] n_wdata0, n_wdata1;
  logic          n_ack0, n_err0, n_ack1, n_err1;
  logic [DW-1:0] n_rdata0, n_rdata1;
  logic [AW-1:0] n_mem_addr;
  logic [DW-1:0] n_mem_wdata, n_mem_rdata;
  logic          n_mem_read, n_mem_write;
  logic [7:0]    n_mem [0:(1<<AW)-1];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CHECK_ALIGN(0)) dut_na (
    .clk(clk), .rst(rst),
    .req0(n_req0), .we0(n_we0), .addr0(n_addr0), .wdata0(n_wdata0),
    .req1(n_req1), .we1(n_we1), .addr1(n_addr1), .wdata1(n_wdata1),
    .ack0(n_ack0), .err0(n_err0), .rdata0(n_rdata0),
    .ack1(n_ack1), .err1(n_err1), .rdata1(n_rdata1),
    .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .mem_rdata(n_mem_rdata)
  );

  assign n_mem_rdata = n_mem_read ? {n_mem[n_mem_addr + 14'd3], n_mem[n_mem_addr + 14'd2],
                                     n_mem[n_mem_addr + 14'd1], n_mem[n_mem_addr]} : 32'hBAD0BAD0;
  always @(posedge clk) begin
    if (n_mem_write) begin
      n_mem[n_mem_addr]         <= n_mem_wdata[7:0];
      n_mem[n_mem_addr + 14'd1] <= n_mem_wdata[15:8];
      n_mem[n_mem_addr + 14'd2] <= n_mem_wdata[23:16];
      n_mem[n_mem_addr + 14'd3] <= n_mem_wdata[31:24];
    end
  end

  // Scoreboard
  typedef struct {
    int          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  logic [31:0] exp_rd [0:1];
  int          checks = 0;
  int          fails  = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Push the expected completion; reads also update the model's rdata.
  function automatic void expect_op(input int p, input bit is_wr, input bit is_err,
                                    input logic [31:0] rd);
    if (!is_wr && !is_err) exp_rd[p] = rd;
    expq.push_back('{port: p, err: is_err, rdata: exp_rd[p]});
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read)  rd_cnt++;
      if (mem_write) wr_cnt++;
      check("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      if (ack0 || ack1) begin
        check("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
        if (expq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_ack: ack0=%b ack1=%b, required no ack (t=%0t)", ack0, ack1, $time);
        end else begin
          mon_e = expq.pop_front();
          check("ack_port", {31'b0, ack1}, mon_e.port);
          check("ack_err", {31'b0, mon_e.port == 1 ? err1 : err0}, {31'b0, mon_e.err});
          check("ack_rdata", mon_e.port == 1 ? rdata1 : rdata0, mon_e.rdata);
        end
      end
    end
  end

  task automatic set_port(input int p, input bit r, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Wait for ackN (bounded), drop req, then let the DONE cycle close.
  task automatic wait_ack(input int p, input int exp_lat);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      got = (p == 0) ? ack0 : ack1;
    end
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL ack_timeout: port %0d got no ack in %0d cycles", p, n);
    end else if (exp_lat != 0) begin
      check($sformatf("latency_p%0d", p), n, exp_lat);
    end
    @(posedge clk);
  endtask

  task automatic drive(input int p, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int exp_lat);
    @(negedge clk);
    set_port(p, 1'b1, w, a, d);
    wait_ack(p, exp_lat);
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  initial begin
    int r0;
    int w0;
    int n;
    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    n_req0 = 1'b0; n_we0 = 1'b0; n_addr0 = '0; n_wdata0 = '0;
    n_req1 = 1'b0; n_we1 = 1'b0; n_addr1 = '0; n_wdata1 = '0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]   = 8'h00;
      n_mem[i] = 8'h00;
    end

    // T1: reset with both requests held; port 0 must win the first tie.
    set_port(0, 1'b1, 1'b1, 14'h0010, 32'hDEADBEEF);
    set_port(1, 1'b1, 1'b1, 14'h0040, 32'h11111111);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {30'b0, ack0, ack1}, 32'd0);
    check("rst_err", {30'b0, err0, err1}, 32'd0);
    check("rst_mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_mem_addr", {18'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    expect_op(0, 1'b1, 1'b0, '0);
    expect_op(1, 1'b1, 1'b0, '0);
    rst = 1'b0;
    fork
      wait_ack(0, 2);
      wait_ack(1, 5);
    join

    // T2: read back the word port 0 wrote; check little-endian bytes.
    check("t2_byte10", {24'b0, mem[16]}, 32'hEF);
    check("t2_byte11", {24'b0, mem[17]}, 32'hBE);
    check("t2_byte12", {24'b0, mem[18]}, 32'hAD);
    check("t2_byte13", {24'b0, mem[19]}, 32'hDE);
    expect_op(0, 1'b0, 1'b0, 32'hDEADBEEF);
    drive(0, 1'b0, 14'h0010, '0, 2);
    // Port 1 read makes port 1 the last grant, so the next tie goes to port 0.
    expect_op(1, 1'b0, 1'b0, 32'h11111111);
    drive(1, 1'b0, 14'h0040, '0, 2);

    // T3: contention, expected order 0,1,0,1.
    w0 = wr_cnt;
    expect_op(0, 1'b1, 1'b0, '0);
    expect_op(1, 1'b1, 1'b0, '0);
    expect_op(0, 1'b1, 1'b0, '0);
    expect_op(1, 1'b1, 1'b0, '0);
    fork
      begin
        drive(0, 1'b1, 14'h0020, 32'hA0A0A0A0, 0);
        drive(0, 1'b1, 14'h0020, 32'hA1A1A1A1, 0);
      end
      begin
        drive(1, 1'b1, 14'h0040, 32'hB0B0B0B0, 0);
        drive(1, 1'b1, 14'h0040, 32'hB1B1B1B1, 0);
      end
    join
    check("t3_write_cycles", wr_cnt - w0, 32'd4);
    check("t3_word20", mem_word(32'h20), 32'hA1A1A1A1);
    check("t3_word40", mem_word(32'h40), 32'hB1B1B1B1);

    // T4: misaligned read on port 1 -> error in one cycle, no memory read.
    r0 = rd_cnt;
    expect_op(1, 1'b0, 1'b1, '0);
    drive(1, 1'b0, 14'h0013, '0, 1);
    check("t4_no_mem_read", rd_cnt - r0, 32'd0);

    // T4b: same request with alignment checking disabled.
    n_mem[19] = 8'h01; n_mem[20] = 8'h02; n_mem[21] = 8'h03; n_mem[22] = 8'h04;
    @(negedge clk);
    n_req1 = 1'b1; n_we1 = 1'b0; n_addr1 = 14'h0013;
    n = 0;
    while (!n_ack1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_req1 = 1'b0;
    check("t4b_latency", n, 32'd2);
    check("t4b_err1", {31'b0, n_err1}, 32'd0);
    check("t4b_rdata1", n_rdata1, 32'h04030201);
    @(posedge clk);

    // T5: top word, no wrap into address 0.
    expect_op(0, 1'b1, 1'b0, '0);
    drive(0, 1'b1, 14'h3FFC, 32'h12345678, 2);
    expect_op(0, 1'b0, 1'b0, 32'h12345678);
    drive(0, 1'b0, 14'h3FFC, '0, 2);
    check("t5_top_word", mem_word(32'h3FFC), 32'h12345678);
    check("t5_no_wrap", mem_word(0), 32'd0);

    // T6: reset during ACCESS of a port 1 read; no ack may follow.
    @(negedge clk);
    set_port(1, 1'b1, 1'b0, 14'h0040, '0);
    @(posedge clk);
    #1;
    check("t6_in_access", {31'b0, mem_read}, 32'd1);
    rst = 1'b1;
    req1 = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_ack1", {31'b0, ack1}, 32'd0);
    check("t6_rst_strobe", {31'b0, mem_read}, 32'd0);
    check("t6_rst_rdata1", rdata1, 32'd0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t6_no_ack1", {31'b0, ack1}, 32'd0);
    end
    expect_op(1, 1'b0, 1'b0, 32'hB1B1B1B1);
    drive(1, 1'b0, 14'h0040, '0, 2);

    repeat (3) @(posedge clk);
    check("queue_drained", expq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
